// File: rtl/conv_pkg.sv
// Shared types and constant helpers for the streaming convolution engine
// and the requantisation stage reused by other layer blocks.
package conv_pkg;

  localparam int ACC_W_DEF = 24;

  typedef logic signed [ACC_W_DEF-1:0] acc_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BIAS  = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Never returns less than 1 so single-entry memories still get a 1-bit address.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((64'd1 << width) < 64'(value)) width = width + 1;
    return width;
  endfunction

  function automatic int out_dim(input int in_sz, input int k, input int s, input int p);
    return (in_sz + 2 * p - k) / s + 1;
  endfunction

  function automatic longint rnd_bias(input int shift);
    if (shift > 0) return 64'sd1 <<< (shift - 1);
    else return 64'sd0;
  endfunction

  function automatic longint sat_hi(input int dw);
    return (64'sd1 <<< (dw - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_lo(input int dw);
    return -(64'sd1 <<< (dw - 1));
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Requantises a wide accumulator to DATA_W: round-half-up shift, saturate,
// optional ReLU. Purely combinational.
module requant_sat
  import conv_pkg::*;
#(
  parameter int ACC_W     = ACC_W_DEF,
  parameter int DATA_W    = 8,
  parameter int OUT_SHIFT = 4
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  input  logic                     relu_i,
  output logic signed [DATA_W-1:0] data_o
);

  // One guard bit keeps the rounding add from wrapping near the top of the range.
  localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'(rnd_bias(OUT_SHIFT));
  localparam logic signed [ACC_W:0] HI  = (ACC_W + 1)'(sat_hi(DATA_W));
  localparam logic signed [ACC_W:0] LO  = (ACC_W + 1)'(sat_lo(DATA_W));

  logic signed [ACC_W:0]    rounded_s;
  logic signed [ACC_W:0]    shifted_s;
  logic signed [DATA_W-1:0] clamped_s;

  always_comb begin
    rounded_s = {acc_i[ACC_W-1], acc_i} + RND;
    shifted_s = rounded_s >>> OUT_SHIFT;
    if (shifted_s > HI) begin
      clamped_s = HI[DATA_W-1:0];
    end else if (shifted_s < LO) begin
      clamped_s = LO[DATA_W-1:0];
    end else begin
      clamped_s = shifted_s[DATA_W-1:0];
    end
    if (relu_i && clamped_s[DATA_W-1]) begin
      data_o = '0;
    end else begin
      data_o = clamped_s;
    end
  end

endmodule

// File: rtl/conv2d_stream_engine.sv
// Parametrised 2-D convolution layer: one MAC per cycle against 1-cycle-latency
// input/weight/bias memories, requantised results streamed on valid/ready.
module conv2d_stream_engine
  import conv_pkg::*;
#(
  parameter int IN_CH     = 4,
  parameter int OUT_CH    = 4,
  parameter int IN_H      = 8,
  parameter int IN_W      = 8,
  parameter int K         = 3,
  parameter int STRIDE    = 1,
  parameter int PAD       = 1,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 24,
  parameter int OUT_SHIFT = 4,
  localparam int OH       = out_dim(IN_H, K, STRIDE, PAD),
  localparam int OW       = out_dim(IN_W, K, STRIDE, PAD),
  localparam int IN_AW    = clog2(IN_CH * IN_H * IN_W),
  localparam int W_AW     = clog2(OUT_CH * IN_CH * K * K),
  localparam int B_AW     = clog2(OUT_CH),
  localparam int O_AW     = clog2(OUT_CH * OH * OW)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     cfg_relu,
  output logic                     busy,
  output logic                     done,
  output logic [IN_AW-1:0]         in_addr,
  output logic                     in_en,
  input  logic signed [DATA_W-1:0] in_data,
  output logic [W_AW-1:0]          w_addr,
  output logic                     w_en,
  input  logic signed [DATA_W-1:0] w_data,
  output logic [B_AW-1:0]          b_addr,
  output logic                     b_en,
  input  logic signed [ACC_W-1:0]  b_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [O_AW-1:0]          out_addr
);

  localparam int OC_W = clog2(OUT_CH);
  localparam int OH_W = clog2(OH);
  localparam int OW_W = clog2(OW);
  localparam int IC_W = clog2(IN_CH);
  localparam int K_W  = clog2(K);

  state_e                   state_q, state_d;
  logic                     relu_q, relu_d;
  logic                     pad_q, pad_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [OC_W-1:0]          oc_q, oc_d;
  logic [OH_W-1:0]          oh_q, oh_d;
  logic [OW_W-1:0]          ow_q, ow_d;
  logic [IC_W-1:0]          ic_q, ic_d;
  logic [K_W-1:0]           kr_q, kr_d, kc_q, kc_d;

  logic signed [2*DATA_W-1:0] mul_s;
  logic signed [ACC_W-1:0]    prod_s;
  int                         row_s, col_s;
  logic                       tap_in_s, first_tap_s, last_pix_s;

  // Product of the tap issued last cycle; a padding tap contributes zero.
  always_comb begin
    mul_s = (2 * DATA_W)'(in_data) * (2 * DATA_W)'(w_data);
    if (pad_q) begin
      prod_s = '0;
    end else begin
      prod_s = ACC_W'(mul_s);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      relu_q  <= 1'b0;
      pad_q   <= 1'b0;
      acc_q   <= '0;
      oc_q    <= '0;
      oh_q    <= '0;
      ow_q    <= '0;
      ic_q    <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
    end else begin
      state_q <= state_d;
      relu_q  <= relu_d;
      pad_q   <= pad_d;
      acc_q   <= acc_d;
      oc_q    <= oc_d;
      oh_q    <= oh_d;
      ow_q    <= ow_d;
      ic_q    <= ic_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
    end
  end

  // Next-state, loop counters, accumulator and memory/stream controls
  always_comb begin
    state_d   = state_q;
    relu_d    = relu_q;
    pad_d     = 1'b0;
    acc_d     = acc_q;
    oc_d      = oc_q;
    oh_d      = oh_q;
    ow_d      = ow_q;
    ic_d      = ic_q;
    kr_d      = kr_q;
    kc_d      = kc_q;
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    in_en     = 1'b0;
    w_en      = 1'b0;
    b_en      = 1'b0;
    in_addr   = '0;
    w_addr    = '0;
    b_addr    = '0;
    out_addr  = '0;

    row_s       = int'(oh_q) * STRIDE + int'(kr_q) - PAD;
    col_s       = int'(ow_q) * STRIDE + int'(kc_q) - PAD;
    tap_in_s    = (row_s >= 0) && (row_s < IN_H) && (col_s >= 0) && (col_s < IN_W);
    first_tap_s = (ic_q == '0) && (kr_q == '0) && (kc_q == '0);
    last_pix_s  = (oc_q == OC_W'(OUT_CH - 1)) && (oh_q == OH_W'(OH - 1)) &&
                  (ow_q == OW_W'(OW - 1));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          relu_d  = cfg_relu;
          acc_d   = '0;
          oc_d    = '0;
          oh_d    = '0;
          ow_d    = '0;
          ic_d    = '0;
          kr_d    = '0;
          kc_d    = '0;
          state_d = S_BIAS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BIAS: begin
        busy    = 1'b1;
        b_en    = 1'b1;
        b_addr  = oc_q;
        state_d = S_MAC;
      end
      S_MAC: begin
        busy   = 1'b1;
        w_en   = 1'b1;
        in_en  = tap_in_s;
        pad_d  = ~tap_in_s;
        w_addr = W_AW'(((int'(oc_q) * IN_CH + int'(ic_q)) * K + int'(kr_q)) * K + int'(kc_q));
        if (tap_in_s) begin
          in_addr = IN_AW'(int'(ic_q) * IN_H * IN_W + row_s * IN_W + col_s);
        end else begin
          in_addr = '0;
        end
        // Bias read in BIAS lands on the first MAC cycle and seeds the sum.
        if (first_tap_s) begin
          acc_d = b_data;
        end else begin
          acc_d = acc_q + prod_s;
        end
        if (kc_q == K_W'(K - 1)) begin
          kc_d = '0;
          if (kr_q == K_W'(K - 1)) begin
            kr_d = '0;
            if (ic_q == IC_W'(IN_CH - 1)) begin
              ic_d    = '0;
              state_d = S_DRAIN;
            end else begin
              ic_d = ic_q + 1'b1;
            end
          end else begin
            kr_d = kr_q + 1'b1;
          end
        end else begin
          kc_d = kc_q + 1'b1;
        end
      end
      S_DRAIN: begin
        busy    = 1'b1;
        acc_d   = acc_q + prod_s;
        state_d = S_OUT;
      end
      S_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_addr  = O_AW'(int'(oc_q) * OH * OW + int'(oh_q) * OW + int'(ow_q));
        if (out_ready) begin
          if (last_pix_s) begin
            state_d = S_DONE;
          end else begin
            state_d = S_BIAS;
            if (ow_q == OW_W'(OW - 1)) begin
              ow_d = '0;
              if (oh_q == OH_W'(OH - 1)) begin
                oh_d = '0;
                oc_d = oc_q + 1'b1;
              end else begin
                oh_d = oh_q + 1'b1;
              end
            end else begin
              ow_d = ow_q + 1'b1;
            end
          end
        end else begin
          state_d = S_OUT;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  requant_sat #(
    .ACC_W    (ACC_W),
    .DATA_W   (DATA_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_requant (
    .acc_i (acc_q),
    .relu_i(relu_q),
    .data_o(out_data)
  );

endmodule

// File: doc/conv2d_stream_engine.md
Name: conv2d_stream_engine

Overview:
- Parametrised successor to the fixed-size conv2d block. Computes one 2-D convolution layer (single batch) with arbitrary channel counts, kernel size, stride and padding.
- Performs one MAC per cycle against external 1-cycle-latency input, weight and bias memories.
- Requantises each accumulator with rounding shift, saturation and optional ReLU.
- Streams results out on a valid/ready handshake, so downstream layers can apply backpressure.

Parameters:
- IN_CH, 4, input channel count (>=1, no upper limit)
- OUT_CH, 4, output channel count
- IN_H, 8, input height
- IN_W, 8, input width
- K, 3, kernel size (square)
- STRIDE, 1, convolution stride
- PAD, 1, zero padding on each edge
- DATA_W, 8, signed activation and weight width
- ACC_W, 24, signed accumulator and bias width
- OUT_SHIFT, 4, requantisation right shift (0 = none)
- IN_AW / W_AW / O_AW, derived, clog2 of the respective memory sizes

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  start pulse; sampled only in IDLE
- cfg_relu  in  1  enable ReLU; latched at start
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last output handshake
- in_addr  out  IN_AW  input address: ic*IN_H*IN_W + r*IN_W + c
- in_en  out  1  input read enable
- in_data  in  DATA_W  signed input data; valid the cycle after in_en
- w_addr  out  W_AW  weight address: ((oc*IN_CH+ic)*K+kr)*K+kc
- w_en  out  1  weight read enable
- w_data  in  DATA_W  signed weight; valid the cycle after w_en
- b_addr  out  clog2(OUT_CH)  bias address = oc
- b_en  out  1  bias read enable
- b_data  in  ACC_W  signed bias; valid the cycle after b_en
- out_valid  out  1  result available
- out_ready  in  1  downstream accept
- out_data  out  DATA_W  requantised result
- out_addr  out  O_AW  oc*OH*OW + oh*OW + ow

Behaviour:
- OH = (IN_H+2*PAD-K)/STRIDE+1; OW is computed the same way from IN_W.
- Loop order, outermost to innermost: oc, oh, ow, ic, kr, kc.
- States: IDLE, BIAS, MAC, DRAIN, OUT, DONE.
- IDLE: start=1 latches cfg_relu, zeroes all counters, sets busy=1, moves to BIAS. start in any other state is ignored.
- BIAS (1 cycle): b_en=1, b_addr=oc, then MAC.
- MAC (IN_CH*K*K cycles): each cycle issues one tap.
  - In-bounds tap: in_en=w_en=1.
  - Padding tap (r or c outside the input): in_en=0, w_en=1, and a pipelined pad flag forces the product to 0.
  - First MAC cycle: acc <= sign-extended b_data.
  - Every later cycle: acc <= acc + product of the previous tap.
  - The full DATA_W x DATA_W product is sign-extended to ACC_W; accumulation wraps at ACC_W (sizing ACC_W is the integrator's responsibility).
- DRAIN (1 cycle): adds the last product; no enables asserted.
- OUT: out_valid=1 with out_data and out_addr held stable until out_ready=1. out_ready=1 in the same cycle valid first rises counts as a transfer.
  - After transfer: if this was the last pixel go to DONE, else advance the ow/oh/oc counters and go to BIAS.
  - Latency from BIAS to first out_valid = IN_CH*K*K + 2 cycles.
- Requantisation (combinational from acc):
  - If OUT_SHIFT>0, add 2^(OUT_SHIFT-1), then arithmetic shift right by OUT_SHIFT.
  - Clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - If relu is set, clamp negative results to 0.
- DONE: done=1 for one cycle, busy=0, return to IDLE. The next cycle can accept start.
- Reset values: state=IDLE, busy=done=out_valid=0, all enables=0, all addresses/out_data/acc=0.
- Reset mid-operation aborts immediately; no partial output is emitted afterwards.
- Enables are deasserted in every state except BIAS and MAC, so memories see no reads during stalls.

Decomposition:
- Shared package conv_pkg:
  - Functions: out_dim(in,k,s,p), clog2.
  - Typedef: acc_t (signed ACC_W).
  - Constants: requant rounding and saturation bounds.
- Natural sub-module requant_sat: acc in, relu in, DATA_W out. Purely combinational; shared with future pooling and fully-connected blocks.

Test Plan:
- IN_CH=1, K=3, PAD=1, STRIDE=1, 4x4 input all 1, weights all 1, bias 0, OUT_SHIFT=0, out_ready=1 -> 16 outputs; corners=4, edges=6, interior=9; done pulses once; out_addr 0..15 in order.
- Same config with STRIDE=2 -> OH=OW=2; outputs 4,6,6,9 at addresses 0..3.
- IN_CH=3, OUT_CH=2, inputs 100, weights 100, bias 0, OUT_SHIFT=4 -> acc=270000 -> 16875 -> saturates to 127; with weights -100 -> -128, and with relu=1 -> 0.
- Rounding: bias=24, all weights 0, OUT_SHIFT=4 -> out_data=2 (24+8=32>>4); bias=-24 -> -1.
- Backpressure: out_ready held low for 5 cycles during the first OUT -> out_valid, out_data and out_addr stay stable; in_en/w_en/b_en remain 0; the result is unchanged after release.
- rst asserted mid-MAC, then start again -> busy drops the cycle after rst; the rerun output sequence matches a clean run; no stray out_valid or done.
